// File: rtl/stopwatch_core.sv
// Prescaled 32-bit stopwatch: two-state IDLE/RUN controller with a saturating count.
// Optional lap capture register is enabled by defining STOPWATCH_LAP_EN.
module stopwatch_core (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] prescaler_init,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
`ifdef STOPWATCH_LAP_EN
    input  logic        lap,
    output logic [31:0] lap_value,
`endif
    output logic [31:0] curr_count,
    output logic        running,
    output logic        overflow
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t      state_reg, state_next;
    logic [31:0] count_reg, count_next;
    logic [31:0] period_reg, period_next;
    logic [31:0] presc_reg, presc_next;
    logic        ovf_reg, ovf_next;
    logic [31:0] init_eff;

    // A zero period would never reach the reload point, so it behaves as 1.
    assign init_eff = (prescaler_init == 32'd0) ? 32'd1 : prescaler_init;

`ifdef STOPWATCH_LAP_EN
    logic [31:0] lap_reg, lap_next;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            count_reg  <= 32'd0;
            period_reg <= 32'd0;
            presc_reg  <= 32'd0;
            ovf_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            period_reg <= period_next;
            presc_reg  <= presc_next;
            ovf_reg    <= ovf_next;
        end
    end

`ifdef STOPWATCH_LAP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lap_reg <= 32'd0;
        end else begin
            lap_reg <= lap_next;
        end
    end
`endif

    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        period_next = period_reg;
        presc_next  = presc_reg;
        ovf_next    = ovf_reg;
`ifdef STOPWATCH_LAP_EN
        lap_next    = lap_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (start && !stop) begin
                    state_next  = RUN;
                    count_next  = 32'd0;
                    ovf_next    = 1'b0;
                    period_next = init_eff;
                    presc_next  = init_eff;
`ifdef STOPWATCH_LAP_EN
                    lap_next    = 32'd0;
`endif
                end else if (clear && !start) begin
                    count_next = 32'd0;
                    ovf_next   = 1'b0;
                end
            end
            RUN: begin
`ifdef STOPWATCH_LAP_EN
                if (lap) begin
                    lap_next = count_reg;
                end
`endif
                // Stop takes priority over a due increment and drops the partial tick.
                if (stop) begin
                    state_next = IDLE;
                    presc_next = 32'd0;
                end else if (presc_reg == 32'd1) begin
                    presc_next = period_reg;
                    if (count_reg == 32'hFFFF_FFFF) begin
                        ovf_next = 1'b1;
                    end else begin
                        count_next = count_reg + 32'd1;
                    end
                end else begin
                    presc_next = presc_reg - 32'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign curr_count = count_reg;
    assign running    = (state_reg == RUN);
    assign overflow   = ovf_reg;
`ifdef STOPWATCH_LAP_EN
    assign lap_value  = lap_reg;
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed scoreboard bench for stopwatch_core; lap checks are built when STOPWATCH_LAP_EN is defined.
module tb_stopwatch_core;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] prescaler_init;
    logic        start, stop, clear;
    logic [31:0] curr_count;
    logic        running, overflow;
`ifdef STOPWATCH_LAP_EN
    logic        lap;
    logic [31:0] lap_value;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic [31:0] count;
        logic        run;
        logic        ovf;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    stopwatch_core dut (
        .clk(clk),
        .reset(reset),
        .prescaler_init(prescaler_init),
        .start(start),
        .stop(stop),
        .clear(clear),
`ifdef STOPWATCH_LAP_EN
        .lap(lap),
        .lap_value(lap_value),
`endif
        .curr_count(curr_count),
        .running(running),
        .overflow(overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Push the expected post-edge state, advance one edge, then pop and compare.
    task automatic step(input string tag, input logic [31:0] cnt, input logic run, input logic ovf);
        exp_t e;
        e.tag = tag; e.count = cnt; e.run = run; e.ovf = ovf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0; stop = 1'b0; clear = 1'b0;
`ifdef STOPWATCH_LAP_EN
        lap = 1'b0;
`endif
        e = sb.pop_front();
        chk({e.tag, ".count"}, curr_count, e.count);
        chk({e.tag, ".running"}, {31'd0, running}, {31'd0, e.run});
        chk({e.tag, ".overflow"}, {31'd0, overflow}, {31'd0, e.ovf});
        $display("step %s: count=%h running=%0d overflow=%0d", e.tag, curr_count, running, overflow);
    endtask

    initial begin
        reset = 1'b1; prescaler_init = 32'd0;
        start = 1'b0; stop = 1'b0; clear = 1'b0;
`ifdef STOPWATCH_LAP_EN
        lap = 1'b0;
`endif
        #3;
        chk("reset.count", curr_count, 32'd0);
        chk("reset.running", {31'd0, running}, 32'd0);
        chk("reset.overflow", {31'd0, overflow}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // start together with stop in IDLE is ignored
        prescaler_init = 32'd4; start = 1'b1; stop = 1'b1;
        step("start_stop_idle", 32'd0, 1'b0, 1'b0);

        // period 4: count 1,2,3 after edges 4,8,12; init changes while running are ignored
        prescaler_init = 32'd4; start = 1'b1;
        step("start_p4", 32'd0, 1'b1, 1'b0);
        prescaler_init = 32'd1;
        for (int m = 1; m <= 3; m++) begin
            for (int i = 1; i <= 4; i++) begin
                step($sformatf("p4_m%0d_i%0d", m, i), (i == 4) ? m : m - 1, 1'b1, 1'b0);
            end
        end
        start = 1'b1;
        step("start_in_run", 32'd3, 1'b1, 1'b0);
        clear = 1'b1;
        step("clear_in_run", 32'd3, 1'b1, 1'b0);
        stop = 1'b1;
        step("stop_p4", 32'd3, 1'b0, 1'b0);
        step("idle_hold", 32'd3, 1'b0, 1'b0);

        // period 3: stop coincides with the 2->3 increment
        prescaler_init = 32'd3; start = 1'b1; clear = 1'b1;
        step("start_clear_p3", 32'd0, 1'b1, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            step($sformatf("p3_i%0d", i), i / 3, 1'b1, 1'b0);
        end
        stop = 1'b1;
        step("stop_wins", 32'd2, 1'b0, 1'b0);
        clear = 1'b1;
        step("clear_idle", 32'd0, 1'b0, 1'b0);

        // period 0 behaves as period 1
        prescaler_init = 32'd0; start = 1'b1;
        step("start_p0", 32'd0, 1'b1, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            step($sformatf("p0_i%0d", i), i, 1'b1, 1'b0);
        end

        // saturation: jump the count close to the top and let it run into the ceiling
        force dut.count_reg = 32'hFFFF_FFFD;
        #1;
        release dut.count_reg;
        step("sat_fe", 32'hFFFF_FFFE, 1'b1, 1'b0);
        step("sat_ff", 32'hFFFF_FFFF, 1'b1, 1'b0);
        step("sat_ovf", 32'hFFFF_FFFF, 1'b1, 1'b1);
        step("sat_hold", 32'hFFFF_FFFF, 1'b1, 1'b1);
        stop = 1'b1;
        step("sat_stop", 32'hFFFF_FFFF, 1'b0, 1'b1);
        prescaler_init = 32'd2; start = 1'b1;
        step("sat_restart", 32'd0, 1'b1, 1'b0);

        // asynchronous reset mid-run
        step("pre_rst_1", 32'd0, 1'b1, 1'b0);
        step("pre_rst_2", 32'd1, 1'b1, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst.count", curr_count, 32'd0);
        chk("async_rst.running", {31'd0, running}, 32'd0);
        chk("async_rst.overflow", {31'd0, overflow}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        step("post_rst_idle", 32'd0, 1'b0, 1'b0);

`ifdef STOPWATCH_LAP_EN
        prescaler_init = 32'd2; start = 1'b1;
        step("lap_start", 32'd0, 1'b1, 1'b0);
        chk("lap_zero", lap_value, 32'd0);
        for (int i = 1; i <= 10; i++) begin
            step($sformatf("lap_run_i%0d", i), i / 2, 1'b1, 1'b0);
        end
        lap = 1'b1;
        step("lap_capture", 32'd5, 1'b1, 1'b0);
        chk("lap_value5", lap_value, 32'd5);
        step("lap_continue", 32'd6, 1'b1, 1'b0);
        stop = 1'b1;
        step("lap_stop", 32'd6, 1'b0, 1'b0);
        lap = 1'b1;
        step("lap_idle", 32'd6, 1'b0, 1'b0);
        chk("lap_idle_hold", lap_value, 32'd5);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stopwatch_core.md
STOPWATCH_CORE -- requirements
Module: stopwatch_core

Interface
REQ-001: Parameters SHALL be none; all widths are fixed at 32 bits.
REQ-002: Clocking SHALL be one clock; reset is asynchronous and active-high.
REQ-003: clk  input  1  system clock; all state changes on its rising edge.
REQ-004: reset  input  1  asynchronous, active-high reset.
REQ-005: prescaler_init  input  32  clk cycles per count increment; sampled only when a start is accepted.
REQ-006: start  input  1  single-cycle request to zero and start counting.
REQ-007: stop  input  1  single-cycle request to halt counting.
REQ-008: clear  input  1  single-cycle request to zero the count while stopped.
REQ-009: curr_count  output  32  elapsed prescaled ticks.
REQ-010: running  output  1  high while counting.
REQ-011: overflow  output  1  sticky saturation flag.
REQ-012: lap  input  1  capture request; present only with STOPWATCH_LAP_EN.
REQ-013: lap_value  output  32  last captured count; present only with STOPWATCH_LAP_EN.

Function
REQ-014: The FSM SHALL have exactly two states, IDLE and RUN; running is high exactly in RUN.
REQ-015: In IDLE, start=1 with stop=0 SHALL set the following at the next edge:
- curr_count=0
- overflow=0
- prescaler period latched as max(prescaler_init,1)
- prescaler counter loaded with that period
- state RUN
REQ-016: In IDLE, start=1 with stop=1 SHALL be ignored; the state is unchanged.
REQ-017: In RUN, the prescaler counter SHALL decrement each cycle.
REQ-018: In RUN, when the prescaler counter equals 1, the following SHALL happen at the same edge:
- reload the prescaler counter with the latched period
- increment curr_count by 1
REQ-019: With latched period N, a start accepted at edge k SHALL give curr_count=m after edge k+m*N.
REQ-020: Changes on prescaler_init while in RUN SHALL have no effect.
REQ-021: In RUN, stop=1 SHALL enter IDLE at the next edge:
- curr_count holds its value
- overflow holds its value
- the partial prescaler count is discarded
REQ-022: A stop coinciding with a due increment SHALL win; no increment occurs.
REQ-023: In RUN, start SHALL be ignored; no restart occurs.
REQ-024: In RUN, clear SHALL be ignored.
REQ-025: In IDLE, clear=1 without start SHALL set curr_count=0 and overflow=0 at the next edge.
REQ-026: In IDLE, start together with clear SHALL behave as start alone.
REQ-027: At curr_count=0xFFFFFFFF, a due increment SHALL leave the count unchanged and set overflow=1; there is no wrap-around.
REQ-028: overflow SHALL clear only on reset, an accepted start, or clear in IDLE.
REQ-029: Outputs SHALL be driven directly from registers; there are no combinational input-to-output paths.

Reset
REQ-030: Asserting reset SHALL immediately, without a clock, set:
- state IDLE
- curr_count=0
- running=0
- overflow=0
- prescaler counter=0
- latched period=0
- lap_value=0 when present
REQ-031: Reset asserted mid-RUN SHALL abort counting; the first edge after deassertion is ordinary IDLE behaviour.

Configuration
REQ-032: Macro STOPWATCH_LAP_EN SHALL, when defined, add the lap and lap_value ports.
REQ-033: With STOPWATCH_LAP_EN defined, lap=1 in RUN SHALL load lap_value with the pre-edge curr_count at the next edge; counting is unaffected.
REQ-034: With STOPWATCH_LAP_EN defined, lap SHALL be ignored in IDLE.
REQ-035: With STOPWATCH_LAP_EN defined, an accepted start SHALL zero lap_value.
REQ-036: Without STOPWATCH_LAP_EN, the lap and lap_value ports and their registers SHALL be absent; all other behaviour is identical.

Verification
REQ-037: prescaler_init=4, start at edge 0 -> running=1 after edge 0; curr_count=1,2,3 after edges 4,8,12.
REQ-038: prescaler_init=0, start -> curr_count increments every cycle, identical to prescaler_init=1.
REQ-039: prescaler_init=3, stop on the same cycle the count 2->3 is due -> running=0, curr_count stays 2; a following clear -> 0.
REQ-040: Count forced near 0xFFFFFFFE with prescaler 1 -> reaches 0xFFFFFFFF, then overflow=1 and the count holds; a new start -> count=0, overflow=0.
REQ-041: Simultaneous events:
- start+stop in IDLE -> no change
- start mid-RUN -> no restart
- reset asserted mid-RUN -> all outputs 0 immediately
REQ-042: With STOPWATCH_LAP_EN, prescaler 2, lap when curr_count=5 -> lap_value=5 and counting continues; lap in IDLE -> lap_value unchanged.
